aq_vpu_gpr_wb_req: RTL

//  VPU-side initiator of the VPU->RTU GPR writeback channel. Buffers scalar-GPR results

---
 rtl/aq_vpu_gpr_wb_req.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/aq_vpu_gpr_wb_req.sv
// VPU -> RTU scalar GPR writeback initiator.
// Results from the VPU pipeline are queued in a small in-order FIFO. The head
// entry drives the writeback request and retires on RTU grant. The FIFO
// fill level comes from a counter, so the pointers only wrap and are never
// compared. VPU fflags/vxsat are registered toward the RTU alongside the FIFO.
module aq_vpu_gpr_wb_req #(
    parameter int DEPTH     = 2,
    parameter int PTR_W     = 1,
    // Protocol check for a push offered while the FIFO is full
    parameter bit PROTO_CHK = 1'b1
) (
    input  logic        forever_cpuclk,
    input  logic        cpurst_b,
    input  logic        cp0_vpu_icg_en,
    input  logic        cp0_yy_clk_en,
    input  logic        pad_yy_icg_scan_en,
    input  logic        vpu_wb_gpr_vld,
    input  logic [5:0]  vpu_wb_gpr_index,
    input  logic [63:0] vpu_wb_gpr_data,
    output logic        vpu_wb_gpr_rdy,
    input  logic        rtu_vpu_gpr_wb_grnt,
    output logic        vpu_rtu_gpr_wb_req,
    output logic [5:0]  vpu_rtu_gpr_wb_index,
    output logic [63:0] vpu_rtu_gpr_wb_data,
    input  logic        vpu_wb_fflag_vld,
    input  logic [5:0]  vpu_wb_fflag,
    output logic        vpu_rtu_fflag_vld,
    output logic [5:0]  vpu_rtu_fflag,
    output logic        vpu_wb_idle
);

    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);

    // FIFO control state
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q,  count_d;

    // Entry storage; not reset, contents only meaningful while count != 0
    logic [DEPTH-1:0][5:0]  ent_idx_q;
    logic [DEPTH-1:0][63:0] ent_data_q;

    // Fflag staging toward RTU
    logic       fflag_vld_q;
    logic [5:0] fflag_q, fflag_d;

    logic full;
    logic push;
    logic pop;
    logic ent_clk;

    // Full, and therefore ready, come from registered state only. A pop in the
    // same cycle does not open a slot for the incoming result.
    assign full           = (count_q == FULL_CNT);
    assign vpu_wb_gpr_rdy = ~full;
    assign push           = vpu_wb_gpr_vld & ~full;
    assign pop            = vpu_rtu_gpr_wb_req & rtu_vpu_gpr_wb_grnt;

    // The head is muxed from registers. There is no path from grant or from
    // the push inputs to the outputs.
    assign vpu_rtu_gpr_wb_req   = (count_q != '0);
    assign vpu_rtu_gpr_wb_index = ent_idx_q[rd_ptr_q];
    assign vpu_rtu_gpr_wb_data  = ent_data_q[rd_ptr_q];

    assign vpu_rtu_fflag_vld = fflag_vld_q;
    assign vpu_rtu_fflag     = fflag_q;
    assign vpu_wb_idle       = (count_q == '0) & ~fflag_vld_q;

    // Entry clock runs only in cycles where the pipeline offers a result
    gated_clk_cell x_entry_gateclk (
        .clk_in             (forever_cpuclk),
        .global_en          (cp0_yy_clk_en),
        .module_en          (cp0_vpu_icg_en),
        .local_en           (vpu_wb_gpr_vld),
        .external_en        (1'b0),
        .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
        .clk_out            (ent_clk)
    );

    // Next-state for the pointers and the count; the pointers wrap mod DEPTH
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers run on the ungated core clock
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Write the accepted result into the tail slot
    always_ff @(posedge ent_clk) begin
        if (push) begin
            ent_idx_q[wr_ptr_q]  <= vpu_wb_gpr_index;
            ent_data_q[wr_ptr_q] <= vpu_wb_gpr_data;
        end
    end

    // Fflag value holds between updates. The valid bit is a plain one-cycle delay.
    always_comb begin
        fflag_d = fflag_q;
        if (vpu_wb_fflag_vld) begin
            fflag_d = vpu_wb_fflag;
        end
    end

    // Fflag registers, independent of GPR FIFO ordering
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            fflag_vld_q <= 1'b0;
            fflag_q     <= '0;
        end else begin
            fflag_vld_q <= vpu_wb_fflag_vld;
            fflag_q     <= fflag_d;
        end
    end

    // An offered result is dropped while the FIFO is full. Upstream must honour ready.
    no_push_when_full: assert property (
        @(posedge forever_cpuclk) disable iff (!cpurst_b)
        !PROTO_CHK || !(vpu_wb_gpr_vld && full)
    );

endmodule

// Latch-based clock gate. The enable is captured while the clock is low, so
// the gated clock cannot glitch when the enable changes mid-cycle.
module gated_clk_cell (
    input  logic clk_in,
    input  logic global_en,
    input  logic module_en,
    input  logic local_en,
    input  logic external_en,
    input  logic pad_yy_icg_scan_en,
    output logic clk_out
);

    logic clk_en;
    logic en_lat_q;

    assign clk_en = (global_en & (module_en | local_en)) | external_en;

    // Transparent while the clock is low; scan forces the clock on
    always_latch begin
        if (!clk_in) begin
            en_lat_q <= clk_en | pad_yy_icg_scan_en;
        end
    end

    assign clk_out = clk_in & en_lat_q;

endmodule
